// File: rtl/sw_reader.sv
// sw_reader: debounced switch bank read over a level-request / one-shot-ack port; SW_READER_IRQ_EN adds a change interrupt irq_o
module sw_reader #(
    parameter int SW_WIDTH        = 10,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                clk_i,
    input  logic                reset,
    input  logic [SW_WIDTH-1:0] SW_i,
    input  logic                rd_req_i,
    output logic                rd_ack_o,
    output logic [31:0]         rd_data_o
`ifdef SW_READER_IRQ_EN
    ,
    output logic                irq_o
`endif
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    typedef enum logic [1:0] {IDLE, ACK, WAIT_LOW} state_t;
    state_t              state;
    logic [SW_WIDTH-1:0] sync1, sync2, cand, stable;
    logic [CW-1:0]       cnt;
    logic                chg, settled, set_chg, take;
    assign settled = (sync2 == cand) && (cnt == LAST);
    assign set_chg = settled && (cand != stable);
    assign take    = (state == IDLE) && rd_req_i;
    // synchronize, then accept a level only after it has been steady for DEBOUNCE_CYCLES
    always_ff @(posedge clk_i) begin
        if (reset) begin
            sync1  <= '0;
            sync2  <= '0;
            cand   <= '0;
            cnt    <= '0;
            stable <= '0;
        end else begin
            sync1 <= SW_i;
            sync2 <= sync1;
            if (sync2 != cand) begin
                cand <= sync2;
                cnt  <= '0;
            end else if (cnt != LAST) begin
                cnt <= cnt + 1'b1;
            end else if (set_chg) begin
                stable <= cand;
            end
        end
    end
    // read handshake: one ack per request level, snapshot taken on the accepting edge; a new change beats the clear
    always_ff @(posedge clk_i) begin
        if (reset) begin
            state     <= IDLE;
            rd_ack_o  <= 1'b0;
            rd_data_o <= '0;
            chg       <= 1'b0;
        end else begin
            chg      <= set_chg | (chg & ~take);
            rd_ack_o <= take;
            if (take) rd_data_o <= 32'({chg, stable});
            state <= take ? ACK :
                     (state == ACK) ? WAIT_LOW :
                     (state == WAIT_LOW && !rd_req_i) ? IDLE : state;
        end
    end
`ifdef SW_READER_IRQ_EN
    // interrupt level follows chg one cycle later
    always_ff @(posedge clk_i) begin
        irq_o <= reset ? 1'b0 : chg;
    end
`endif
endmodule

// File: tb/tb_sw_reader.sv
// tb_sw_reader: directed and randomized checks of sw_reader against a sliding-window behavioural model
module tb_sw_reader;
    localparam int W  = 10;
    localparam int DB = 4;
    logic          clk_i = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  SW_i = '0;
    logic          rd_req_i = 1'b0;
    logic          rd_ack_o;
    logic [31:0]   rd_data_o;
`ifdef SW_READER_IRQ_EN
    logic          irq_o;
`endif
    int n_chk = 0;
    int n_fail = 0;

    sw_reader #(.SW_WIDTH(W), .DEBOUNCE_CYCLES(DB)) dut (
        .clk_i     (clk_i),
        .reset     (reset),
        .SW_i      (SW_i),
        .rd_req_i  (rd_req_i),
        .rd_ack_o  (rd_ack_o),
        .rd_data_o (rd_data_o)
`ifdef SW_READER_IRQ_EN
        ,
        .irq_o     (irq_o)
`endif
    );

    initial forever #5 clk_i = ~clk_i;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: after reset, sample i is SW_i seen on post-reset edge i (samples <= 0 read as 0).
    // On edge e (e >= DB) stable takes sample e-2 when samples e-2-DB .. e-2 are all equal.
    logic [W-1:0] hist[$];
    int           e;
    int           low_ok;
    bit           armed;
    logic [W-1:0] m_stable;
    logic         m_chg, m_ack, m_irq, m_upd, m_take;
    logic [31:0]  m_data;

    function automatic logic [W-1:0] smp(input int i);
        return (i <= 0) ? '0 : hist[i-1];
    endfunction

    always @(posedge clk_i) begin
        if (reset) begin
            hist.delete();
            e = 0; low_ok = 0; armed = 1;
            m_stable = '0; m_chg = 0; m_ack = 0; m_irq = 0; m_data = '0;
        end else begin
            e++;
            m_upd = (e >= DB);
            for (int i = e - 2 - DB; i < e - 2; i++)
                if (smp(i) != smp(e - 2)) m_upd = 0;
            m_take = rd_req_i && armed;
            m_irq = m_chg;
            m_ack = m_take;
            if (m_take) begin
                m_data = {21'd0, m_chg, m_stable};
                armed = 0;
                low_ok = e + 2;
            end else if (!armed && !rd_req_i && e >= low_ok) begin
                armed = 1;
            end
            m_chg = (m_upd && smp(e - 2) != m_stable) | (m_chg & !m_take);
            if (m_upd) m_stable = smp(e - 2);
            hist.push_back(SW_i);
        end
    end

    always @(posedge clk_i) begin
        #1;
        check("ack", 32'(rd_ack_o), 32'(m_ack));
        check("data", rd_data_o, m_data);
`ifdef SW_READER_IRQ_EN
        check("irq", 32'(irq_o), 32'(m_irq));
`endif
    end

    task automatic rd(input string nm, input logic [31:0] exp);
        rd_req_i = 1'b1;
        @(negedge clk_i);
        check({nm, "_ack"}, 32'(rd_ack_o), 32'd1);
        check(nm, rd_data_o, exp);
        rd_req_i = 1'b0;
        repeat (3) @(negedge clk_i);
    endtask

    initial begin
        int acks;
        int hold;
        SW_i = 10'b0000110010;
        repeat (3) @(negedge clk_i);
        check("rst_data", rd_data_o, 32'd0);
        check("rst_ack", 32'(rd_ack_o), 32'd0);
        reset = 1'b0;
        repeat (8) @(negedge clk_i);
`ifdef SW_READER_IRQ_EN
        check("irq_set", 32'(irq_o), 32'd1);
`endif
        rd("first_read", 32'h432);
`ifdef SW_READER_IRQ_EN
        check("irq_clr", 32'(irq_o), 32'd0);
`endif
        rd("second_read", 32'h032);
        SW_i = 10'h033;
        repeat (3) @(negedge clk_i);
        SW_i = 10'h032;
        repeat (10) @(negedge clk_i);
`ifdef SW_READER_IRQ_EN
        check("glitch_irq", 32'(irq_o), 32'd0);
`endif
        rd("glitch", 32'h032);
        rd_req_i = 1'b1;
        acks = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            if (k == 0) check("req_rise_ack", 32'(rd_ack_o), 32'd1);
            acks += int'(rd_ack_o);
        end
        check("held_acks", 32'(acks), 32'd1);
        rd_req_i = 1'b0;
        @(negedge clk_i);
        rd_req_i = 1'b1;
        @(negedge clk_i);
        check("reack", 32'(rd_ack_o), 32'd1);
        rd_req_i = 1'b0;
        repeat (3) @(negedge clk_i);
        SW_i = 10'h155;
        repeat (6) @(negedge clk_i);
        rd("coincide_old", 32'h032);
        rd("coincide_new", 32'h555);
        SW_i = 10'h3FF;
        repeat (2) @(negedge clk_i);
        reset = 1'b1;
        repeat (2) @(negedge clk_i);
        reset = 1'b0;
        repeat (6) @(negedge clk_i);
        rd("rst_mid_edge7", 32'h000);
        reset = 1'b1;
        repeat (2) @(negedge clk_i);
        reset = 1'b0;
        repeat (7) @(negedge clk_i);
        rd("rst_mid_edge8", 32'h7FF);
        hold = 0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk_i);
            if (hold == 0) begin
                SW_i = ($urandom_range(0, 3) == 0) ? W'($urandom) : SW_i ^ W'(1 << $urandom_range(0, W - 1));
                hold = $urandom_range(1, 9);
            end
            hold--;
            if ($urandom_range(0, 2) == 0) rd_req_i = ~rd_req_i;
            reset = ($urandom_range(0, 99) == 0);
        end
        reset = 1'b0;
        rd_req_i = 1'b0;
        repeat (4) @(negedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
